// File: rtl/reg_file_wb.sv
// Register file with write-through bypass and pending-write scoreboard for the ID/WB boundary.
// Reads combinational, writes and scoreboard updates 1 edge; no handshake, every edge sampled.
module reg_file_wb #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] raddr1,
   input  logic [ADDR_WIDTH-1:0] raddr2,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [DATA_WIDTH-1:0] rdata2,
   output logic                  busy1,
   output logic                  busy2,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  issue,
   input  logic [ADDR_WIDTH-1:0] iaddr,
   input  logic                  flush
);

   localparam int NREGS = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_regs [NREGS];
   logic [NREGS-1:0]      r_pend;
   logic [NREGS-1:0]      w_pend_nxt;
   logic                  w_wr_en;
   logic                  w_set_en;

   // Gating with rst keeps the bypass from leaking wdata while reset is held.
   assign w_wr_en  = we && (waddr != '0) && !rst;
   assign w_set_en = issue && (iaddr != '0);

   always_comb begin
      w_pend_nxt = r_pend;
      if (w_wr_en) begin
         w_pend_nxt[waddr] = 1'b0;
      end
      if (w_set_en) begin
         w_pend_nxt[iaddr] = 1'b1;
      end
      if (flush) begin
         w_pend_nxt = '0;
      end
      w_pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
         r_pend <= '0;
      end else begin
         if (w_wr_en) begin
            r_regs[waddr] <= wdata;
         end
         r_pend <= w_pend_nxt;
      end
   end

   always_comb begin
      rdata1 = '0;
      rdata2 = '0;
      if (raddr1 != '0) begin
         rdata1 = (w_wr_en && (waddr == raddr1)) ? wdata : r_regs[raddr1];
      end
      if (raddr2 != '0) begin
         rdata2 = (w_wr_en && (waddr == raddr2)) ? wdata : r_regs[raddr2];
      end
   end

   // A write retiring this cycle is served by the bypass, so it is not a hazard.
   assign busy1 = r_pend[raddr1] & ~(w_wr_en && (waddr == raddr1));
   assign busy2 = r_pend[raddr2] & ~(w_wr_en && (waddr == raddr2));

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb: reset, bypass, R0, scoreboard lifecycle, same-cycle events, width.
module tb_reg_file_wb;

   logic        clk;
   logic        rst;
   logic [2:0]  raddr1;
   logic [2:0]  raddr2;
   logic [15:0] rdata1;
   logic [15:0] rdata2;
   logic        busy1;
   logic        busy2;
   logic        we;
   logic [2:0]  waddr;
   logic [15:0] wdata;
   logic        issue;
   logic [2:0]  iaddr;
   logic        flush;

   int checks;
   int failures;

   reg_file_wb #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
      .clk(clk), .rst(rst),
      .raddr1(raddr1), .raddr2(raddr2),
      .rdata1(rdata1), .rdata2(rdata2),
      .busy1(busy1), .busy2(busy2),
      .we(we), .waddr(waddr), .wdata(wdata),
      .issue(issue), .iaddr(iaddr), .flush(flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 1'b0; issue = 1'b0; flush = 1'b0;
   endtask

   task automatic test_reset();
      logic [15:0] exp;
      // held reset with active enables
      we = 1'b1; waddr = 3'd3; wdata = 16'hABCD; issue = 1'b1; iaddr = 3'd3;
      raddr1 = 3'd3; raddr2 = 3'd0;
      tick();
      checks++;
      if (rdata1 !== 16'h0000) begin
         failures++; $display("FAIL reset_hold_rdata1 got=%h exp=0000", rdata1);
      end
      checks++;
      if (busy1 !== 1'b0) begin
         failures++; $display("FAIL reset_hold_busy1 got=%b exp=0", busy1);
      end
      idle();
      rst = 1'b0;
      tick();
      checks++;
      if (rdata1 !== 16'h0000 || busy1 !== 1'b0) begin
         failures++; $display("FAIL reset_release got=%h/%b exp=0000/0", rdata1, busy1);
      end
      // load regs 1..7
      for (int i = 1; i < 8; i++) begin
         we = 1'b1; waddr = 3'(i); wdata = 16'(16'h1111 * i);
         tick();
      end
      we = 1'b0;
      issue = 1'b1; iaddr = 3'd5;
      tick();
      issue = 1'b0;
      for (int i = 0; i < 8; i++) begin
         raddr1 = 3'(i);
         #1;
         exp = 16'(16'h1111 * i);
         checks++;
         if (rdata1 !== exp) begin
            failures++; $display("FAIL load_readback a=%0d got=%h exp=%h", i, rdata1, exp);
         end
      end
      raddr2 = 3'd5;
      #1;
      checks++;
      if (busy2 !== 1'b1) begin
         failures++; $display("FAIL pre_reset_busy2 got=%b exp=1", busy2);
      end
      // asynchronous assertion between edges
      #2;
      rst = 1'b1;
      #1;
      for (int i = 0; i < 8; i++) begin
         raddr1 = 3'(i); raddr2 = 3'(7 - i);
         #1;
         checks++;
         if (rdata1 !== 16'h0000 || rdata2 !== 16'h0000 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
            failures++;
            $display("FAIL async_reset a=%0d got=%h/%h/%b/%b exp=0000/0000/0/0",
                     i, rdata1, rdata2, busy1, busy2);
         end
      end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_bypass();
      we = 1'b1; waddr = 3'd3; wdata = 16'hBEEF; raddr1 = 3'd3; raddr2 = 3'd5;
      #1;
      checks++;
      if (rdata1 !== 16'hBEEF) begin
         failures++; $display("FAIL bypass_same_cycle got=%h exp=beef", rdata1);
      end
      checks++;
      if (rdata2 !== 16'h0000) begin
         failures++; $display("FAIL bypass_other_port got=%h exp=0000", rdata2);
      end
      tick();
      we = 1'b0; wdata = 16'h5A5A;
      #1;
      checks++;
      if (rdata1 !== 16'hBEEF) begin
         failures++; $display("FAIL write_stored got=%h exp=beef", rdata1);
      end
      checks++;
      if (rdata2 !== 16'h0000) begin
         failures++; $display("FAIL write_unaffected got=%h exp=0000", rdata2);
      end
   endtask

   task automatic test_r0();
      we = 1'b1; waddr = 3'd0; wdata = 16'hFFFF; raddr1 = 3'd0; raddr2 = 3'd0;
      #1;
      checks++;
      if (rdata1 !== 16'h0000) begin
         failures++; $display("FAIL r0_no_bypass got=%h exp=0000", rdata1);
      end
      tick();
      we = 1'b0; issue = 1'b1; iaddr = 3'd0;
      tick();
      issue = 1'b0;
      #1;
      checks++;
      if (rdata1 !== 16'h0000 || busy1 !== 1'b0) begin
         failures++; $display("FAIL r0_protect got=%h/%b exp=0000/0", rdata1, busy1);
      end
   endtask

   task automatic test_scoreboard();
      raddr1 = 3'd4;
      issue = 1'b1; iaddr = 3'd4;
      #1;
      checks++;
      if (busy1 !== 1'b0) begin
         failures++; $display("FAIL issue_same_cycle got=%b exp=0", busy1);
      end
      tick();
      issue = 1'b0;
      #1;
      checks++;
      if (busy1 !== 1'b1) begin
         failures++; $display("FAIL issue_next_cycle got=%b exp=1", busy1);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (busy1 !== 1'b1) begin
            failures++; $display("FAIL busy_hold idle=%0d got=%b exp=1", i, busy1);
         end
      end
      we = 1'b1; waddr = 3'd4; wdata = 16'h1234;
      #1;
      checks++;
      if (busy1 !== 1'b0 || rdata1 !== 16'h1234) begin
         failures++; $display("FAIL retire_same_cycle got=%b/%h exp=0/1234", busy1, rdata1);
      end
      tick();
      we = 1'b0;
      #1;
      checks++;
      if (busy1 !== 1'b0 || rdata1 !== 16'h1234) begin
         failures++; $display("FAIL retire_after got=%b/%h exp=0/1234", busy1, rdata1);
      end
   endtask

   task automatic test_simultaneous();
      raddr1 = 3'd2; raddr2 = 3'd1;
      issue = 1'b1; iaddr = 3'd2;
      tick();
      checks++;
      if (busy1 !== 1'b1) begin
         failures++; $display("FAIL pend2_set got=%b exp=1", busy1);
      end
      // set and clear on the same register: set wins
      we = 1'b1; waddr = 3'd2; wdata = 16'h2A2A;
      #1;
      checks++;
      if (busy1 !== 1'b0) begin
         failures++; $display("FAIL same_reg_bypass_busy got=%b exp=0", busy1);
      end
      tick();
      we = 1'b0; issue = 1'b0;
      #1;
      checks++;
      if (busy1 !== 1'b1 || rdata1 !== 16'h2A2A) begin
         failures++; $display("FAIL set_wins got=%b/%h exp=1/2a2a", busy1, rdata1);
      end
      // set and clear on different registers
      issue = 1'b1; iaddr = 3'd1; we = 1'b1; waddr = 3'd2; wdata = 16'h0202;
      tick();
      idle();
      #1;
      checks++;
      if (busy1 !== 1'b0 || busy2 !== 1'b1) begin
         failures++; $display("FAIL diff_regs got=%b/%b exp=0/1", busy1, busy2);
      end
      // flush beats a same-cycle issue
      issue = 1'b1; iaddr = 3'd6; flush = 1'b1;
      tick();
      idle();
      for (int i = 0; i < 8; i++) begin
         raddr1 = 3'(i); raddr2 = 3'(7 - i);
         #1;
         checks++;
         if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
            failures++; $display("FAIL flush a=%0d got=%b/%b exp=0/0", i, busy1, busy2);
         end
      end
   endtask

   task automatic test_wrap();
      raddr1 = 3'd7; raddr2 = 3'd0;
      we = 1'b1; waddr = 3'd7; wdata = 16'h0000;
      tick();
      we = 1'b0;
      #1;
      checks++;
      if (rdata1 !== 16'h0000) begin
         failures++; $display("FAIL wrap_zero got=%h exp=0000", rdata1);
      end
      we = 1'b1; wdata = 16'hFFFF;
      tick();
      we = 1'b0;
      #1;
      checks++;
      if (rdata1 !== 16'hFFFF) begin
         failures++; $display("FAIL wrap_ones got=%h exp=ffff", rdata1);
      end
      checks++;
      if (rdata2 !== 16'h0000) begin
         failures++; $display("FAIL r7_r0_alias got=%h exp=0000", rdata2);
      end
   endtask

   task automatic test_back_to_back();
      raddr1 = 3'd1; raddr2 = 3'd6;
      we = 1'b1; waddr = 3'd1; wdata = 16'hC001;
      tick();
      waddr = 3'd6; wdata = 16'hC006;
      #1;
      checks++;
      if (rdata1 !== 16'hC001 || rdata2 !== 16'hC006) begin
         failures++; $display("FAIL b2b_mid got=%h/%h exp=c001/c006", rdata1, rdata2);
      end
      tick();
      we = 1'b0;
      #1;
      checks++;
      if (rdata1 !== 16'hC001 || rdata2 !== 16'hC006) begin
         failures++; $display("FAIL b2b_final got=%h/%h exp=c001/c006", rdata1, rdata2);
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      rst = 1'b1;
      raddr1 = '0; raddr2 = '0;
      we = 1'b0; waddr = '0; wdata = '0;
      issue = 1'b0; iaddr = '0; flush = 1'b0;
      test_reset();
      test_bypass();
      test_r0();
      test_scoreboard();
      test_simultaneous();
      test_wrap();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_file_wb.md
# reg_file_wb

Register file with a write-back port and a pending-write scoreboard for the 16-bit pipelined MIPS core. It sits between decode (ID) and write-back (WB). ID reads two source operands and marks a destination register as pending. WB writes results back, which clears the pending mark. The block decodes a single write port onto N registers and provides the busy flags the hazard unit needs for stall decisions.

## Interface
- DATA_WIDTH, 16, register width in bits
- ADDR_WIDTH, 3, register address width; NREGS = 2**ADDR_WIDTH = 8
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- raddr1  input  ADDR_WIDTH  read port 1 address
- raddr2  input  ADDR_WIDTH  read port 2 address
- rdata1  output  DATA_WIDTH  read port 1 data (combinational)
- rdata2  output  DATA_WIDTH  read port 2 data (combinational)
- busy1  output  1  register at raddr1 has a pending write
- busy2  output  1  register at raddr2 has a pending write
- we  input  1  write-back enable
- waddr  input  ADDR_WIDTH  write-back destination
- wdata  input  DATA_WIDTH  write-back data
- issue  input  1  ID issues an instruction that writes register iaddr
- iaddr  input  ADDR_WIDTH  destination being issued
- flush  input  1  synchronous clear of all pending marks (branch squash)

## Operation
- Storage: regs[0..NREGS-1], each DATA_WIDTH wide.
  - regs[0] is hardwired to zero. Writes to address 0 are ignored.
- Write: on rising clk with we=1 and waddr!=0, regs[waddr] <= wdata.
- Read: rdataN = regs[raddrN], with write-through bypass.
  - When we=1, waddr==raddrN and waddr!=0, rdataN = wdata in the same cycle.
  - Address 0 always reads 0.
- Scoreboard: pend[0..NREGS-1], one bit per register. pend[0] is always 0.
  - Set: issue=1 and iaddr!=0 sets pend[iaddr] at the clock edge.
  - Clear: we=1 and waddr!=0 clears pend[waddr] at the clock edge.
  - Set and clear on the same register in the same cycle: set wins. A new producer supersedes the retiring one.
  - Set and clear on different registers in the same cycle: both take effect.
  - flush=1: all pend bits clear at the edge. An issue in the same cycle is also discarded, so flush has priority.
- busyN = pend[raddrN] & ~(we & waddr==raddrN & waddr!=0).
  - A write retiring this cycle is not busy, because the bypass already supplies the data.
- Write data and scoreboard are independent: a write to a register that is not pending still updates it.

## Timing
- Reset (rst=1, asynchronous): all regs clear to 0 and all pend bits clear.
  - Resulting outputs: rdata1=rdata2=0 and busy1=busy2=0 for as long as rst is held.
- Release of rst takes effect at the next rising clk. No writes or sets occur while rst=1.
- Reset asserted mid-operation overrides any same-cycle we, issue or flush.
- Read latency is 0 cycles (combinational from raddr, we, waddr, wdata).
- Write latency is 1 edge: the stored value is visible through the non-bypass path in the cycle after the write.
- Scoreboard update latency is 1 edge. busy reflects an issue starting the cycle after issue=1.
- No handshake. we, issue and flush are sampled every edge, and X on an address with its enable low is tolerated.

## Test plan
- Reset: load regs 1..7 with 16'h1111*i, then assert rst asynchronously between edges. rdata1/rdata2 read 0 for every address immediately and busy=0.
- Write/read with bypass:
  - we=1, waddr=3, wdata=16'hBEEF, raddr1=3: rdata1=16'hBEEF in the same cycle.
  - After the edge with we=0: still 16'hBEEF.
  - raddr2=5 is unaffected.
- R0 protection: we=1, waddr=0, wdata=16'hFFFF, then issue with iaddr=0. rdata1 at raddr1=0 stays 0 and busy1 stays 0.
- Scoreboard lifecycle:
  - issue iaddr=4: busy1 (raddr1=4) goes 1 from the next cycle.
  - Three idle cycles: busy1 stays 1.
  - we=1, waddr=4: busy1=0 in that cycle, and 0 after the edge.
- Simultaneous events:
  - issue iaddr=2 together with we waddr=2 (pend[2]=1 beforehand): pend[2] remains 1 after the edge.
  - issue iaddr=6 with flush=1: pend[6]=0 and all busy=0 after the edge.
- Width/wrap: write 16'h0000 and 16'hFFFF to reg 7, then read back exactly. raddr=7 and raddr=0 do not alias.
